logic_op_sequencer: RTL
=======================

Name: logic_op_sequencer

Overview:
- Upstream control stage for the 8-bit, 3-bit-select logic unit (8 bitwise ops).
- Accepts operand/opcode commands over a valid/ready handshake and drives registered A, B and s into the logic unit.
- Captures the unit's result one cycle later and presents it downstream over a second valid/ready handshake with status flags.
- Sweep mode issues all 8 ops in order 0..7 on one operand pair, so the whole op table can be dumped without re-issuing commands.

Parameters:
- WIDTH, 8, operand/result width; must match the logic unit width.
- OP_W, 3, select width; the op count is 2**OP_W.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- cmd_op  input  OP_W  op select; ignored when cmd_sweep=1.
- cmd_sweep  input  1  issue ops 0..7 in sequence.
- lu_a  output  WIDTH  registered operand A to logic unit.
- lu_b  output  WIDTH  registered operand B to logic unit.
- lu_s  output  OP_W  registered select to logic unit.
- lu_y  input  WIDTH  combinational result from logic unit.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- res_y  output  WIDTH  captured result.
- res_op  output  OP_W  op that produced res_y.
- res_zero  output  1  res_y == 0.
- res_last  output  1  final result of the current command.

Behaviour:
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NOT A, 4 NOR, 5 XNOR, 6 NOT B, 7 NAND.
- Reset (async, rst=1): state=IDLE.
  - All outputs 0: lu_a, lu_b, lu_s, res_y, res_op, res_zero, res_last, res_valid.
  - cmd_ready=0 while rst is asserted; cmd_ready=1 in the first cycle after rst deasserts.
- States:
  - IDLE: cmd_ready=1.
  - DRIVE: one cycle; lu_* are stable and lu_y settles.
  - HOLD: res_valid=1.
- IDLE -> DRIVE on cmd_valid&&cmd_ready at edge E0.
  - lu_a<=cmd_a, lu_b<=cmd_b.
  - lu_s<=cmd_sweep?0:cmd_op.
  - Internal sweep flag latched.
- DRIVE -> HOLD at edge E1.
  - res_y<=lu_y, res_op<=lu_s, res_zero<=(lu_y==0).
  - res_last<=(!sweep || lu_s==2**OP_W-1).
  - res_valid<=1.
  - Latency: accept to res_valid = 2 edges.
- HOLD, res_ready=0: every res_* output held bit-stable. No input change may alter them.
- HOLD, res_ready=1, res_last=0: res_valid<=0, lu_s<=lu_s+1, -> DRIVE. lu_a/lu_b unchanged.
- HOLD, res_ready=1, res_last=1: res_valid<=0, -> IDLE.
- Throughput: one result per 2 cycles with res_ready tied high. A sweep produces 8 results in 16 cycles from acceptance.
- cmd_ready=0 in DRIVE and HOLD. Commands presented then are not accepted and must be held by the producer.
- lu_s increment never wraps: the sweep stops at 7 because res_last is set.
- res_ready while res_valid=0 is ignored.
- rst mid-command (any state): immediate abort. No partial result is emitted and no remaining sweep ops are issued; restart in IDLE.
- No combinational path from cmd_* or res_ready to any output. All outputs except cmd_ready are registered; cmd_ready decodes from state only.

Decomposition:
- Shared package logic_unit_pkg holds:
  - op encoding constants OP_AND..OP_NAND;
  - the state enum IDLE/DRIVE/HOLD;
  - default WIDTH/OP_W.
- The 8-bit logic unit is instantiated by the parent, not inside this block.
- One sub-module is natural: logic_result_reg. It holds the res_* capture/hold register with the valid/ready skid-free hold logic.
- The bench instantiates logic_op_sequencer plus the existing logic unit, connecting lu_* to it.

Test Plan:
- Single op: A=8'b11001010, B=8'b01101001, op=2, sweep=0, res_ready=1 -> res_valid 2 edges after accept; res_y=8'b10100011, res_op=2, res_last=1, res_zero=0; cmd_ready back to 1 the next cycle.
- Sweep, same A/B, res_ready=1 -> 8 results ops 0..7, every 2 cycles; res_last=1 only on op 7.
  - ops 0..3 res_y = 01001000, 11101011, 10100011, 00110101;
  - ops 4..7 res_y = 00010100, 01011100, 10010110, 10110111.
- Backpressure: sweep with res_ready low for 5 cycles on op 3 -> res_y=00110101 and res_op=3 stable throughout; op 4 follows 2 cycles after res_ready rises; cmd_valid pulsed meanwhile is not accepted.
- Zero flag: A=8'hF0, B=8'h0F, op=0 -> res_y=0, res_zero=1; then op=1 -> res_y=8'hFF, res_zero=0.
- Reset mid-sweep: assert rst asynchronously while in HOLD of op 4 -> all outputs 0 immediately, no further results; a new single op=7 command after release gives res_y=8'b10110111 with res_last=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared op encoding, sequencer states and default widths
package logic_unit_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int OP_W_DEF  = 3;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NOT_A = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOT_B = 3'd6;
  localparam logic [2:0] OP_NAND  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/logic_result_reg.sv
// rtl/logic_result_reg.sv - result capture register, held bit-stable until the consumer takes it
module logic_result_reg
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] y_o,
  output logic [OP_W-1:0]  op_o,
  output logic             zero_o,
  output logic             last_o
);

  logic             valid_q;
  logic [WIDTH-1:0] y_q;
  logic [OP_W-1:0]  op_q;
  logic             zero_q;
  logic             last_q;

  // Payload only changes on capture; a completed handshake just drops valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      op_q    <= '0;
      zero_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (capture_i) begin
      valid_q <= 1'b1;
      y_q     <= y_i;
      op_q    <= op_i;
      zero_q  <= (y_i == '0);
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign y_o     = y_q;
  assign op_o    = op_q;
  assign zero_o  = zero_q;
  assign last_o  = last_q;

endmodule

// File: rtl/logic_op_sequencer.sv
// rtl/logic_op_sequencer.sv - command sequencer driving an external logic unit, single-op or full sweep
module logic_op_sequencer
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic             cmd_sweep,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [OP_W-1:0]  lu_s,
  input  logic [WIDTH-1:0] lu_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic [OP_W-1:0]  res_op,
  output logic             res_zero,
  output logic             res_last
);

  localparam logic [OP_W-1:0] LAST_OP = {OP_W{1'b1}};

  seq_state_e       state_q;
  logic [WIDTH-1:0] lu_a_q;
  logic [WIDTH-1:0] lu_b_q;
  logic [OP_W-1:0]  lu_s_q;
  logic             sweep_q;
  logic             capture;
  logic             last_d;

  assign capture = (state_q == DRIVE);
  assign last_d  = !sweep_q || (lu_s_q == LAST_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lu_a_q  <= '0;
      lu_b_q  <= '0;
      lu_s_q  <= '0;
      sweep_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            lu_a_q  <= cmd_a;
            lu_b_q  <= cmd_b;
            lu_s_q  <= cmd_sweep ? '0 : cmd_op;
            sweep_q <= cmd_sweep;
            state_q <= DRIVE;
          end
        end
        DRIVE: state_q <= HOLD;
        HOLD: begin
          // res_last stops a sweep at the top op, so lu_s never wraps.
          if (res_ready) begin
            if (res_last) begin
              state_q <= IDLE;
            end else begin
              lu_s_q  <= lu_s_q + 1'b1;
              state_q <= DRIVE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Held low for the whole of reset even though the state already reads IDLE.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_s      = lu_s_q;

  logic_result_reg #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_result (
    .clk       (clk),
    .rst       (rst),
    .capture_i (capture),
    .y_i       (lu_y),
    .op_i      (lu_s_q),
    .last_i    (last_d),
    .ready_i   (res_ready),
    .valid_o   (res_valid),
    .y_o       (res_y),
    .op_o      (res_op),
    .zero_o    (res_zero),
    .last_o    (res_last)
  );

endmodule
